// File: rtl/option_feeder.sv
// option_feeder: transmit end of the nonogram solver's option stream.
// Holds candidate line options in a circular FIFO with per-line counts and
// streams them line by line, re-queuing the options the solver keeps.
module option_feeder #(
   parameter int unsigned SIZE  = 11,
   parameter int unsigned OPT_W = 16,
   parameter int unsigned CNT_W = 7,
   parameter int unsigned DEPTH = 512
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [3:0]                num_rows,
   input  logic [3:0]                num_cols,
   input  logic                      load_start,
   input  logic                      load_valid,
   input  logic                      load_is_index,
   input  logic [OPT_W-1:0]          load_data,
   input  logic                      load_end,
   output logic                      load_ready,
   output logic                      started,
   output logic [OPT_W-1:0]          option,
   output logic [2*SIZE*CNT_W-1:0]   old_options_amnt,
   input  logic                      new_line,
   input  logic                      put_back_to_FIFO,
   input  logic                      solved,
   output logic                      done,
   output logic                      stalled,
   output logic                      overflow
);
   localparam int unsigned NL = 2 * SIZE;
   localparam int unsigned LW = 5;               // covers num_rows+num_cols <= 30
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned OW = AW + 1;
   localparam int unsigned FW = NL * CNT_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_START, S_IDX, S_OPT, S_GAP, S_WAIT, S_DONE
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [LW-1:0]      r_line, w_line_nxt;
   logic               r_prog, w_prog_nxt;
   logic [CNT_W-1:0]   r_n, w_n_nxt;
   logic [CNT_W-1:0]   r_k, w_k_nxt;
   logic [CNT_W-1:0]   r_newcnt, w_newcnt_nxt;
   logic [LW-1:0]      r_cur_line, w_cur_line_nxt;
   logic               r_cur_ok, w_cur_ok_nxt;
   logic               r_stalled, w_stalled_nxt;
   logic               r_ovf, w_ovf_nxt;
   logic [OPT_W-1:0]   r_option, w_option_nxt;
   logic               r_load_ready, r_started, r_done;
   logic [AW-1:0]      r_head, r_tail, w_head_nxt, w_tail_nxt;
   logic [OW-1:0]      r_occ, w_occ_nxt;
   logic [OPT_W-1:0]   r_mem [DEPTH];
   logic [CNT_W-1:0]   r_cnt [NL];
   logic [FW-1:0]      w_amnt;
   logic               w_clr, w_pop, w_push, w_cnt_we, w_full;
   logic [OPT_W-1:0]   w_push_data;
   logic [LW-1:0]      w_cnt_idx, w_lim;
   logic [CNT_W-1:0]   w_cnt_val;
   logic [LW:0]        w_f_next, w_f_zero;

   // Lowest line in [from, lim) with a non-zero count, as {found, line}.
   function automatic logic [LW:0] find_line(input logic [LW-1:0] from,
                                             input logic [LW-1:0] lim,
                                             input logic [FW-1:0] cnts);
      logic [LW:0] res;
      res = '0;
      for (int i = NL - 1; i >= 0; i--) begin
         if (LW'(i) >= from && LW'(i) < lim && cnts[i*CNT_W +: CNT_W] != '0)
            res = {1'b1, LW'(i)};
      end
      return res;
   endfunction

   // Flatten count registers onto the solver-facing bus.
   always_comb begin
      w_amnt = '0;
      for (int i = 0; i < NL; i++) w_amnt[i*CNT_W +: CNT_W] = r_cnt[i];
   end

   assign w_lim    = LW'(num_rows) + LW'(num_cols);
   assign w_full   = (r_occ == OW'(DEPTH));
   assign w_f_next = find_line(r_line + LW'(1), w_lim, w_amnt);
   assign w_f_zero = find_line('0, w_lim, w_amnt);

   // Next-state and datapath control.
   always_comb begin
      w_state_nxt    = r_state;
      w_line_nxt     = r_line;
      w_prog_nxt     = r_prog;
      w_n_nxt        = r_n;
      w_k_nxt        = r_k;
      w_newcnt_nxt   = r_newcnt;
      w_cur_line_nxt = r_cur_line;
      w_cur_ok_nxt   = r_cur_ok;
      w_stalled_nxt  = r_stalled;
      w_ovf_nxt      = r_ovf;
      w_clr          = 1'b0;
      w_pop          = 1'b0;
      w_push         = 1'b0;
      w_push_data    = '0;
      w_cnt_we       = 1'b0;
      w_cnt_idx      = r_line;
      w_cnt_val      = '0;
      if (load_start) begin
         w_state_nxt    = S_LOAD;
         w_clr          = 1'b1;
         w_line_nxt     = '0;
         w_prog_nxt     = 1'b0;
         w_n_nxt        = '0;
         w_k_nxt        = '0;
         w_newcnt_nxt   = '0;
         w_cur_line_nxt = '0;
         w_cur_ok_nxt   = 1'b1;
         w_stalled_nxt  = 1'b0;
         w_ovf_nxt      = 1'b0;
      end else if (solved && (r_state inside {S_START, S_IDX, S_OPT, S_GAP, S_WAIT})) begin
         w_state_nxt = S_DONE;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (load_valid) begin
                  if (load_is_index) begin
                     w_cur_line_nxt = LW'(load_data);
                     w_cur_ok_nxt   = (load_data < OPT_W'(NL));
                  end else if (r_cur_ok) begin
                     if (w_full) begin
                        w_ovf_nxt = 1'b1;
                     end else begin
                        w_push      = 1'b1;
                        w_push_data = load_data;
                        w_cnt_we    = 1'b1;
                        w_cnt_idx   = r_cur_line;
                        w_cnt_val   = (r_cnt[r_cur_line] == CNT_MAX) ? CNT_MAX
                                    : r_cnt[r_cur_line] + CNT_W'(1);
                     end
                  end
               end
               if (load_end) w_state_nxt = S_START;
            end
            S_START: begin
               w_prog_nxt = 1'b0;
               if (w_f_zero[LW]) begin
                  w_line_nxt  = w_f_zero[LW-1:0];
                  w_state_nxt = S_IDX;
               end else begin
                  w_stalled_nxt = 1'b1;
                  w_state_nxt   = S_DONE;
               end
            end
            S_IDX: begin
               w_n_nxt      = r_cnt[r_line];
               w_k_nxt      = '0;
               w_newcnt_nxt = '0;
               w_state_nxt  = S_OPT;
            end
            S_OPT: begin
               w_pop = (r_occ != '0);
               if (put_back_to_FIFO) begin
                  w_push       = 1'b1;
                  w_push_data  = r_option;
                  w_newcnt_nxt = r_newcnt + CNT_W'(1);
               end
               if (r_k == r_n - CNT_W'(1)) w_state_nxt = S_GAP;
               else                        w_k_nxt     = r_k + CNT_W'(1);
            end
            S_GAP: begin
               w_cnt_we  = 1'b1;
               w_cnt_val = r_newcnt;
               if (r_newcnt != r_n) w_prog_nxt = 1'b1;
               w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (new_line) begin
                  if (w_f_next[LW]) begin
                     w_line_nxt  = w_f_next[LW-1:0];
                     w_state_nxt = S_IDX;
                  end else if (r_prog && w_f_zero[LW]) begin
                     w_line_nxt  = w_f_zero[LW-1:0];
                     w_prog_nxt  = 1'b0;
                     w_state_nxt = S_IDX;
                  end else begin
                     w_stalled_nxt = 1'b1;
                     w_state_nxt   = S_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // FIFO pointer arithmetic and next presented word.
   always_comb begin
      w_head_nxt = r_head + AW'(w_pop);
      w_tail_nxt = r_tail + AW'(w_push);
      w_occ_nxt  = r_occ + OW'(w_push) - OW'(w_pop);
      if (w_clr) begin
         w_head_nxt = '0;
         w_tail_nxt = '0;
         w_occ_nxt  = '0;
      end
      w_option_nxt = '0;
      if (w_state_nxt == S_IDX)      w_option_nxt = OPT_W'(w_line_nxt);
      else if (w_state_nxt == S_OPT) w_option_nxt = r_mem[w_head_nxt];
   end

   // State, control and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_line       <= '0;
         r_prog       <= 1'b0;
         r_n          <= '0;
         r_k          <= '0;
         r_newcnt     <= '0;
         r_cur_line   <= '0;
         r_cur_ok     <= 1'b1;
         r_stalled    <= 1'b0;
         r_ovf        <= 1'b0;
         r_option     <= '0;
         r_load_ready <= 1'b0;
         r_started    <= 1'b0;
         r_done       <= 1'b0;
         r_head       <= '0;
         r_tail       <= '0;
         r_occ        <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_line       <= w_line_nxt;
         r_prog       <= w_prog_nxt;
         r_n          <= w_n_nxt;
         r_k          <= w_k_nxt;
         r_newcnt     <= w_newcnt_nxt;
         r_cur_line   <= w_cur_line_nxt;
         r_cur_ok     <= w_cur_ok_nxt;
         r_stalled    <= w_stalled_nxt;
         r_ovf        <= w_ovf_nxt;
         r_option     <= w_option_nxt;
         r_load_ready <= (w_state_nxt == S_LOAD);
         r_started    <= (w_state_nxt == S_START);
         r_done       <= (w_state_nxt == S_DONE);
         r_head       <= w_head_nxt;
         r_tail       <= w_tail_nxt;
         r_occ        <= w_occ_nxt;
      end
   end

   // Per-line option counts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NL; i++) r_cnt[i] <= '0;
      end else if (w_clr) begin
         for (int i = 0; i < NL; i++) r_cnt[i] <= '0;
      end else if (w_cnt_we) begin
         r_cnt[w_cnt_idx] <= w_cnt_val;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_tail] <= w_push_data;
   end

   assign load_ready       = r_load_ready;
   assign started          = r_started;
   assign option           = r_option;
   assign old_options_amnt = w_amnt;
   assign done             = r_done;
   assign stalled          = r_stalled;
   assign overflow         = r_ovf;
endmodule

// File: tb/tb_option_feeder.sv
// tb_option_feeder: randomized checks of option_feeder against a queue model.
module tb_option_feeder;
   localparam int unsigned SIZE  = 11;
   localparam int unsigned OPT_W = 16;
   localparam int unsigned CNT_W = 7;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned NL    = 2 * SIZE;
   localparam int unsigned CW    = NL * CNT_W;
   typedef logic [CW-1:0] val_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [3:0]       num_rows, num_cols;
   logic             load_start, load_valid, load_is_index, load_end;
   logic [OPT_W-1:0] load_data;
   logic             load_ready, started, done, stalled, overflow;
   logic [OPT_W-1:0] option;
   logic [CW-1:0]    old_options_amnt;
   logic             new_line, put_back_to_FIFO, solved;

   option_feeder #(.SIZE(SIZE), .OPT_W(OPT_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .num_rows(num_rows), .num_cols(num_cols),
      .load_start(load_start), .load_valid(load_valid), .load_is_index(load_is_index),
      .load_data(load_data), .load_end(load_end), .load_ready(load_ready),
      .started(started), .option(option), .old_options_amnt(old_options_amnt),
      .new_line(new_line), .put_back_to_FIFO(put_back_to_FIFO), .solved(solved),
      .done(done), .stalled(stalled), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int               n_tests = 0;
   int               n_fail  = 0;
   logic [OPT_W-1:0] m_q[$];
   int               m_cnt[NL];
   int               m_cur;
   bit               m_ovf;

   task automatic check(input string tag, input val_t got, input val_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic val_t m_amnt();
      val_t v = '0;
      for (int i = 0; i < NL; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      return v;
   endfunction

   task automatic load_begin(input int r, input int c);
      num_rows   = 4'(r);
      num_cols   = 4'(c);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      m_q.delete();
      for (int i = 0; i < NL; i++) m_cnt[i] = 0;
      m_cur = 0;
      m_ovf = 1'b0;
      check("load_ready", val_t'(load_ready), val_t'(1));
      check("ovf_cleared", val_t'(overflow), val_t'(0));
      check("amnt_cleared", old_options_amnt, '0);
   endtask

   task automatic load_word(input bit is_idx, input logic [OPT_W-1:0] d);
      load_valid    = 1'b1;
      load_is_index = is_idx;
      load_data     = d;
      @(negedge clk);
      load_valid    = 1'b0;
      if (is_idx) m_cur = int'(d);
      else if (m_q.size() < DEPTH) begin
         m_q.push_back(d);
         m_cnt[m_cur]++;
      end else m_ovf = 1'b1;
   endtask

   task automatic load_finish();
      load_end = 1'b1;
      @(negedge clk);
      load_end = 1'b0;
      check("amnt_loaded", old_options_amnt, m_amnt());
      check("started", val_t'(started), val_t'(1));
      check("start_opt", val_t'(option), '0);
   endtask

   task automatic load_s1();
      logic [OPT_W-1:0] w[8] = '{16'b0011, 16'b0110, 16'b1100, 16'b1101,
                                 16'b1000, 16'b0100, 16'b0010, 16'b0001};
      load_begin(4, 4);
      load_word(1'b1, 16'd0);
      for (int i = 0; i < 3; i++) load_word(1'b0, w[i]);
      load_word(1'b1, 16'd3);
      load_word(1'b0, w[3]);
      load_word(1'b1, 16'd5);
      for (int i = 4; i < 8; i++) load_word(1'b0, w[i]);
      load_finish();
   endtask

   // pb_mode: 0 never, 1 always, 2 random, 3 only on pb_word.
   // stop_kind: 0 none, 1 solved, 2 reset, at the first option of stop_line.
   task automatic run_solve(input int pb_mode, input logic [OPT_W-1:0] pb_word,
                            input int stop_line, input int stop_kind, input bit rwait);
      int  lines  = int'(num_rows) + int'(num_cols);
      bit  prog   = 1'b1;
      bit  stopped = 1'b0;
      int  passes = 0;
      new_line = 1'b1;
      while (prog && !stopped && passes < 40) begin
         prog = 1'b0;
         passes++;
         for (int l = 0; l < lines; l++) begin
            int n, nc, d;
            if (m_cnt[l] == 0) continue;
            @(negedge clk);
            check("idx", val_t'(option), val_t'(l));
            check("idx_amnt", old_options_amnt, m_amnt());
            check("idx_done", val_t'(done), '0);
            n  = m_cnt[l];
            nc = 0;
            for (int k = 0; k < n; k++) begin
               logic [OPT_W-1:0] w;
               bit pb;
               @(negedge clk);
               w = m_q.pop_front();
               check("opt", val_t'(option), val_t'(w));
               check("opt_amnt", old_options_amnt, m_amnt());
               if (l == stop_line && k == 0 && stop_kind != 0) begin
                  stopped = 1'b1;
                  break;
               end
               case (pb_mode)
                  1:       pb = 1'b1;
                  2:       pb = ($urandom_range(0, 99) < 55);
                  3:       pb = (w == pb_word);
                  default: pb = 1'b0;
               endcase
               put_back_to_FIFO = pb;
               if (pb) begin
                  m_q.push_back(w);
                  nc++;
               end
            end
            if (stopped) break;
            @(negedge clk);
            put_back_to_FIFO = 1'b0;
            check("gap", val_t'(option), '0);
            m_cnt[l] = nc;
            if (nc != n) prog = 1'b1;
            d = rwait ? int'($urandom_range(0, 2)) : 0;
            if (d != 0) new_line = 1'b0;
            for (int j = 0; j <= d; j++) begin
               @(negedge clk);
               check("wait_opt", val_t'(option), '0);
               check("wait_amnt", old_options_amnt, m_amnt());
               if (j == d) new_line = 1'b1;
            end
         end
      end
      if (stopped && stop_kind == 1) begin
         solved = 1'b1;
         @(negedge clk);
         solved = 1'b0;
         check("solved_done", val_t'(done), val_t'(1));
         check("solved_opt", val_t'(option), '0);
         check("solved_stall", val_t'(stalled), '0);
         for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("halt_opt", val_t'(option), '0);
            check("halt_start", val_t'(started), '0);
         end
      end else if (stopped) begin
         #1 rst_n = 1'b0;
         #1;
         check("rst_opt", val_t'(option), '0);
         check("rst_done", val_t'(done), '0);
         check("rst_stall", val_t'(stalled), '0);
         check("rst_ovf", val_t'(overflow), '0);
         check("rst_ready", val_t'(load_ready), '0);
         check("rst_amnt", old_options_amnt, '0);
         @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         check("idle_ready", val_t'(load_ready), '0);
      end else begin
         @(negedge clk);
         check("end_done", val_t'(done), val_t'(1));
         check("end_stall", val_t'(stalled), val_t'(1));
         check("end_opt", val_t'(option), '0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      num_rows = '0; num_cols = '0;
      load_start = 1'b0; load_valid = 1'b0; load_is_index = 1'b0;
      load_data = '0; load_end = 1'b0;
      new_line = 1'b1; put_back_to_FIFO = 1'b0; solved = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_opt", val_t'(option), '0);
      check("reset_done", val_t'(done), '0);
      check("reset_started", val_t'(started), '0);
      check("reset_ready", val_t'(load_ready), '0);
      check("reset_amnt", old_options_amnt, '0);
      rst_n = 1'b1;
      @(negedge clk);

      load_s1();  run_solve(0, '0, -1, 0, 1'b0);
      load_s1();  run_solve(3, 16'b0110, -1, 0, 1'b0);
      load_s1();  run_solve(1, '0, -1, 0, 1'b0);
      load_s1();  run_solve(0, '0, 3, 1, 1'b0);

      load_begin(4, 4);
      load_word(1'b1, 16'd2);
      for (int i = 0; i < 9; i++) load_word(1'b0, OPT_W'($urandom));
      check("overflow", val_t'(overflow), val_t'(m_ovf));
      load_finish();
      run_solve(2, '0, -1, 0, 1'b0);

      load_s1();  run_solve(0, '0, 5, 2, 1'b0);
      load_s1();  run_solve(0, '0, -1, 0, 1'b0);

      for (int t = 0; t < 25; t++) begin
         int r, c, budget, k;
         r = int'($urandom_range(1, 11));
         c = int'($urandom_range(1, 11));
         budget = int'($urandom_range(0, DEPTH));
         load_begin(r, c);
         for (int l = 0; l < r + c; l++) begin
            k = (budget == 0) ? 0 : int'($urandom_range(0, (budget < 3) ? budget : 3));
            if (k == 0) continue;
            load_word(1'b1, OPT_W'(l));
            for (int i = 0; i < k; i++) load_word(1'b0, OPT_W'($urandom));
            budget -= k;
         end
         load_finish();
         run_solve(2, '0, -1, 0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/option_feeder.md
Name: option_feeder

Overview:
- Upstream driver for the nonogram solver; it is the transmit end of the solver's option-stream interface.
- Holds every candidate line option in a circular FIFO, together with a per-line option count.
- Streams each line to the solver as one index word followed by that line's options.
- Re-enqueues any option the solver flags with put_back_to_FIFO, and repeats passes over all lines until the solver reports solved or a full pass makes no progress.

Parameters:
SIZE, 11, maximum rows and maximum columns.
OPT_W, 16, width of an option word and of an index word.
CNT_W, 7, width of a per-line option count.
DEPTH, 512, FIFO entries; must be a power of two.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
num_rows  in  4  active rows; held stable from load_start to done.
num_cols  in  4  active columns; held stable from load_start to done.
load_start  in  1  pulse: clear all state and enter LOAD.
load_valid  in  1  load word valid.
load_is_index  in  1  load word is a line index, not an option.
load_data  in  OPT_W  load word.
load_end  in  1  pulse: loading complete, begin solving.
load_ready  out  1  high only in LOAD.
started  out  1  one-cycle start pulse to the solver.
option  out  OPT_W  index or option word presented to the solver.
old_options_amnt  out  2*SIZE*CNT_W  per-line counts, line i at bits [i*CNT_W +: CNT_W].
new_line  in  1  solver ready for the next line index.
put_back_to_FIFO  in  1  solver keeps the option presented this cycle.
solved  in  1  solver reports the board complete.
done  out  1  level: terminated.
stalled  out  1  level: terminated without progress.
overflow  out  1  sticky: a write was attempted while the FIFO was full.

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; head, tail, occupancy and all counts = 0; option=0; started, load_ready, done, stalled, overflow = 0.
- Line numbering: rows are 0..num_rows-1; columns are num_rows..num_rows+num_cols-1. L = num_rows+num_cols.
- IDLE:
  - load_start -> LOAD.
  - load_start in any state also returns to LOAD with full clear (overrides everything else).
- LOAD:
  - load_ready=1.
  - On load_valid with load_is_index=1: set cur_line = load_data.
  - On load_valid with load_is_index=0: push load_data to tail and increment count[cur_line].
  - Push while full: drop the word, set overflow.
  - load_end -> START.
- START:
  - started=1 for exactly one cycle.
  - line=0, progress=0; next state is SEL.
- SEL:
  - Skip lines with count 0; zero-count lines take no cycle on the interface.
  - If line==L: progress=1 -> line=0, progress=0, SEL; progress=0 -> DONE with stalled=1.
  - Otherwise -> IDX.
- IDX:
  - option = line, for exactly one cycle.
  - Latch n = count[line]; clear newcnt.
  - Next state is OPT.
- OPT, one cycle per option (n cycles total):
  - option = FIFO head entry; pop head.
  - If put_back_to_FIFO is high that cycle: write the same word to tail and increment newcnt.
  - Pop and push in the same cycle are legal; occupancy is unchanged.
  - After the n-th option -> GAP.
- GAP (one cycle):
  - option = 0.
  - count[line] = newcnt; if newcnt != n, set progress=1.
  - Next state is WAIT.
- WAIT:
  - solved=1 -> DONE.
  - Otherwise new_line=1 -> line+1, SEL.
  - WAIT may last any number of cycles.
- solved sampled high in any state other than IDLE or LOAD -> DONE at the next edge; the option stream halts immediately.
- DONE: done=1; option=0; the FSM holds until load_start or reset.
- old_options_amnt is driven from the count registers at all times.
  - A count updates only in GAP, so the solver sees the old count for the whole line.
- Pointer and width rules:
  - head and tail are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is log2(DEPTH)+1 bits.
  - Counts saturate at 2^CNT_W-1.
- Per-line latency, from IDX to WAIT: n+2 cycles.

Test Plan:
1. Basic 4x4 load/pass:
   - Stimulus: num_rows=4, num_cols=4. Load row 0 = {0011,0110,1100}, row 3 = {1101}, col 1 (line 5) = {1000,0100,0010,0001}; load_end; hold new_line=1.
   - Response: started pulses one cycle after load_end.
   - Line 0 sequence: 0000, 0011, 0110, 1100, gap.
   - Lines 1-2 skipped; line 3 sequence: 0011, 1101, gap.
2. Put-back:
   - Stimulus: assert put_back_to_FIFO only while 0110 is presented for row 0.
   - Response: count[0] becomes 1 in GAP; the next pass presents row 0 as 0000, 0110.
3. No progress:
   - Stimulus: assert put_back_to_FIFO on every option cycle.
   - Response: after one complete unchanged pass, done=1 and stalled=1.
4. Solved mid-line:
   - Stimulus: raise solved during row 3's option cycle.
   - Response: done=1 next cycle, option=0, stalled=0, no further started or index words.
5. FIFO wrap and overflow:
   - Stimulus: DEPTH=8; load 8 options, then a 9th.
   - Response: overflow=1; ninth word dropped; put-backs across the pointer wrap return the correct words.
6. Reset and restart:
   - Stimulus: drop rst_n during OPT.
   - Response: all outputs reset asynchronously. A subsequent load_start and reload reproduces scenario 1 exactly.
